// File: rtl/xb_rt_pkg.sv
// Shared configuration for the route-control crossbar: default field widths,
// port naming and a small multi-hot helper used by every column.
package xb_rt_pkg;

    localparam int NPORTS_DEF    = 5;
    localparam int ADDRBITS2_DEF = 8;
    localparam int HOPBITS_DEF   = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_S = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    function automatic logic is_multi(input logic [31:0] s);
        return (s & (s - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/xb_rt_col.sv
// One output column of the route crossbar: one-hot check, input mux,
// zero-forcing of invalid slots and saturating hop increment. Purely combinational.
module xb_rt_col
    import xb_rt_pkg::*;
#(
    parameter int NPORTS    = NPORTS_DEF,
    parameter int ADDRBITS2 = ADDRBITS2_DEF,
    parameter int HOPBITS   = HOPBITS_DEF,
    parameter int HOP_INC   = 1
) (
    input  logic [NPORTS-1:0]           sel,
    input  logic [NPORTS-1:0]           in_valid,
    input  logic [NPORTS*ADDRBITS2-1:0] in_srcdst,
    input  logic [NPORTS*HOPBITS-1:0]   in_hop,
    output logic                        valid,
    output logic [ADDRBITS2-1:0]        srcdst,
    output logic [HOPBITS-1:0]          hop,
    output logic [NPORTS-1:0]           grant,
    output logic                        multi
);

    function automatic logic [HOPBITS-1:0] sat_inc(input logic [HOPBITS-1:0] h);
        return (&h) ? h : h + HOPBITS'(1);
    endfunction

    assign multi = is_multi(32'(sel));
    assign grant = ((sel != '0) && !multi) ? sel : '0;

    always_comb begin
        valid  = 1'b0;
        srcdst = '0;
        hop    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i] && in_valid[i]) begin
                valid  = 1'b1;
                srcdst = in_srcdst[i*ADDRBITS2 +: ADDRBITS2];
                hop    = (HOP_INC != 0) ? sat_inc(in_hop[i*HOPBITS +: HOPBITS])
                                        : in_hop[i*HOPBITS +: HOPBITS];
            end
        end
    end

endmodule

// File: rtl/xb_rt_pipe.sv
// Pipelined N-port crossbar for route-control fields (srcdst, hop) with
// saturating hop increment and sticky multi-hot / duplicate-grant flags.
module xb_rt_pipe
    import xb_rt_pkg::*;
#(
    parameter int NPORTS    = NPORTS_DEF,
    parameter int ADDRBITS2 = ADDRBITS2_DEF,
    parameter int HOPBITS   = HOPBITS_DEF,
    parameter int STAGES    = 1,
    parameter int HOP_INC   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NPORTS*NPORTS-1:0]    ctl,
    input  logic [NPORTS-1:0]           in_valid,
    input  logic [NPORTS*ADDRBITS2-1:0] in_srcdst,
    input  logic [NPORTS*HOPBITS-1:0]   in_hop,
    output logic [NPORTS-1:0]           out_valid,
    output logic [NPORTS*ADDRBITS2-1:0] out_srcdst,
    output logic [NPORTS*HOPBITS-1:0]   out_hop,
    output logic                        err_multi,
    output logic                        err_dup,
    input  logic                        err_clr
);

    localparam int SW = NPORTS * ADDRBITS2;
    localparam int HW = NPORTS * HOPBITS;

    logic [NPORTS-1:0]        col_valid;
    logic [NPORTS-1:0]        col_multi;
    logic [SW-1:0]            col_srcdst;
    logic [HW-1:0]            col_hop;
    logic [NPORTS*NPORTS-1:0] col_grant;

    for (genvar o = 0; o < NPORTS; o++) begin : g_col
        xb_rt_col #(
            .NPORTS   (NPORTS),
            .ADDRBITS2(ADDRBITS2),
            .HOPBITS  (HOPBITS),
            .HOP_INC  (HOP_INC)
        ) u_col (
            .sel      (ctl[o*NPORTS +: NPORTS]),
            .in_valid (in_valid),
            .in_srcdst(in_srcdst),
            .in_hop   (in_hop),
            .valid    (col_valid[o]),
            .srcdst   (col_srcdst[o*ADDRBITS2 +: ADDRBITS2]),
            .hop      (col_hop[o*HOPBITS +: HOPBITS]),
            .grant    (col_grant[o*NPORTS +: NPORTS]),
            .multi    (col_multi[o])
        );
    end

    // An input granted a second time is a duplicate; only valid inputs count.
    logic [NPORTS-1:0] seen;
    logic [NPORTS-1:0] dup_in;
    logic              dup_det;

    always_comb begin
        seen   = '0;
        dup_in = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (col_grant[o*NPORTS + i]) begin
                    if (seen[i]) dup_in[i] = 1'b1;
                    seen[i] = 1'b1;
                end
            end
        end
    end

    assign dup_det = |(dup_in & in_valid);

    logic [NPORTS-1:0] vld_p0;
    logic [SW-1:0]     srcdst_p0;
    logic [HW-1:0]     hop_p0;

    // Stage 0: select/increment result and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= '0;
            srcdst_p0 <= '0;
            hop_p0    <= '0;
            err_multi <= 1'b0;
            err_dup   <= 1'b0;
        end else begin
            vld_p0    <= col_valid;
            srcdst_p0 <= col_srcdst;
            hop_p0    <= col_hop;
            err_multi <= (|col_multi) ? 1'b1 : (err_clr ? 1'b0 : err_multi);
            err_dup   <= dup_det      ? 1'b1 : (err_clr ? 1'b0 : err_dup);
        end
    end

    if (STAGES == 2) begin : g_two
        logic [NPORTS-1:0] vld_p1;
        logic [SW-1:0]     srcdst_p1;
        logic [HW-1:0]     hop_p1;

        // Stage 1: plain copy of stage 0
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1    <= '0;
                srcdst_p1 <= '0;
                hop_p1    <= '0;
            end else begin
                vld_p1    <= vld_p0;
                srcdst_p1 <= srcdst_p0;
                hop_p1    <= hop_p0;
            end
        end

        assign out_valid  = vld_p1;
        assign out_srcdst = srcdst_p1;
        assign out_hop    = hop_p1;
    end else if (STAGES == 1) begin : g_one
        assign out_valid  = vld_p0;
        assign out_srcdst = srcdst_p0;
        assign out_hop    = hop_p0;
    end else begin : g_bad
        $error("xb_rt_pipe: STAGES must be 1 or 2");
    end

endmodule

// File: tb/tb_xb_rt_pipe.sv
// Bench for xb_rt_pipe: three instances (1 stage, 2 stages, 1 stage without hop
// increment) share stimulus; directed table, hand sequences and random streaming.
module tb_xb_rt_pipe;

    localparam int NP = 5;
    localparam int AB = 8;
    localparam int HB = 5;
    localparam int HOPMAX = (1 << HB) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NP*NP-1:0] ctl = '0;
    logic [NP-1:0]    in_valid = '0;
    logic [NP*AB-1:0] in_srcdst = '0;
    logic [NP*HB-1:0] in_hop = '0;
    logic             err_clr = 1'b0;

    logic [NP-1:0] o1_v, o2_v, o0_v;
    logic [NP*AB-1:0] o1_sd, o2_sd, o0_sd;
    logic [NP*HB-1:0] o1_hp, o2_hp, o0_hp;
    logic o1_em, o1_ed, o2_em, o2_ed, o0_em, o0_ed;

    always #5 clk = ~clk;

    xb_rt_pipe #(.NPORTS(NP), .ADDRBITS2(AB), .HOPBITS(HB), .STAGES(1), .HOP_INC(1)) d1 (
        .clk(clk), .rst_n(rst_n), .ctl(ctl), .in_valid(in_valid), .in_srcdst(in_srcdst),
        .in_hop(in_hop), .out_valid(o1_v), .out_srcdst(o1_sd), .out_hop(o1_hp),
        .err_multi(o1_em), .err_dup(o1_ed), .err_clr(err_clr));
    xb_rt_pipe #(.NPORTS(NP), .ADDRBITS2(AB), .HOPBITS(HB), .STAGES(2), .HOP_INC(1)) d2 (
        .clk(clk), .rst_n(rst_n), .ctl(ctl), .in_valid(in_valid), .in_srcdst(in_srcdst),
        .in_hop(in_hop), .out_valid(o2_v), .out_srcdst(o2_sd), .out_hop(o2_hp),
        .err_multi(o2_em), .err_dup(o2_ed), .err_clr(err_clr));
    xb_rt_pipe #(.NPORTS(NP), .ADDRBITS2(AB), .HOPBITS(HB), .STAGES(1), .HOP_INC(0)) d0 (
        .clk(clk), .rst_n(rst_n), .ctl(ctl), .in_valid(in_valid), .in_srcdst(in_srcdst),
        .in_hop(in_hop), .out_valid(o0_v), .out_srcdst(o0_sd), .out_hop(o0_hp),
        .err_multi(o0_em), .err_dup(o0_ed), .err_clr(err_clr));

    typedef struct packed {
        logic [NP-1:0]    v;
        logic [NP*AB-1:0] sd;
        logic [NP*HB-1:0] hp;
        logic             multi;
        logic             dup;
    } res_t;

    typedef struct packed {
        logic [NP*NP-1:0] ctl;
        logic [NP-1:0]    iv;
        logic [NP*HB-1:0] ih;
        logic [NP-1:0]    ev;
        logic [NP*AB-1:0] esd;
        logic [NP*HB-1:0] eh1;
        logic [NP*HB-1:0] eh0;
        logic             em;
        logic             ed;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    res_t e1_cur, e0_cur, e2_cur, pend;
    logic fm = 1'b0, fd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference: decode each slice by bit count, route, saturate with integer min.
    function automatic res_t model(input logic [NP*NP-1:0] c, input logic [NP-1:0] iv,
                                   input logic [NP*AB-1:0] isd, input logic [NP*HB-1:0] ih,
                                   input bit inc);
        res_t r;
        int   uses[NP];
        int   idx, h;
        logic [NP-1:0] s;
        r = '0;
        for (int k = 0; k < NP; k++) uses[k] = 0;
        for (int o = 0; o < NP; o++) begin
            s = c[o*NP +: NP];
            if ($countones(s) > 1) r.multi = 1'b1;
            else if ($countones(s) == 1) begin
                idx = 0;
                for (int k = 0; k < NP; k++) if (s[k]) idx = k;
                uses[idx]++;
                if (iv[idx]) begin
                    r.v[o] = 1'b1;
                    r.sd[o*AB +: AB] = isd[idx*AB +: AB];
                    h = int'(ih[idx*HB +: HB]);
                    if (inc) h = (h + 1 > HOPMAX) ? HOPMAX : h + 1;
                    r.hp[o*HB +: HB] = HB'(h);
                end
            end
        end
        for (int k = 0; k < NP; k++) if (uses[k] >= 2 && iv[k]) r.dup = 1'b1;
        return r;
    endfunction

    function automatic logic [NP*NP-1:0] ctl5(input logic [4:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction
    function automatic logic [NP*AB-1:0] sd5(input logic [7:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction
    function automatic logic [NP*HB-1:0] hp5(input logic [4:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    // One clock edge with the model advanced alongside.
    task automatic tick();
        logic fm_n, fd_n;
        e1_cur = model(ctl, in_valid, in_srcdst, in_hop, 1'b1);
        e0_cur = model(ctl, in_valid, in_srcdst, in_hop, 1'b0);
        fm_n = e1_cur.multi ? 1'b1 : (err_clr ? 1'b0 : fm);
        fd_n = e1_cur.dup   ? 1'b1 : (err_clr ? 1'b0 : fd);
        @(posedge clk);
        #1;
        e2_cur = pend;
        pend   = e1_cur;
        fm     = fm_n;
        fd     = fd_n;
    endtask

    task automatic step_check(input string tag);
        tick();
        chk({tag, "_d1_valid"}, 64'(o1_v), 64'(e1_cur.v));
        chk({tag, "_d1_srcdst"}, 64'(o1_sd), 64'(e1_cur.sd));
        chk({tag, "_d1_hop"}, 64'(o1_hp), 64'(e1_cur.hp));
        chk({tag, "_d2_valid"}, 64'(o2_v), 64'(e2_cur.v));
        chk({tag, "_d2_srcdst"}, 64'(o2_sd), 64'(e2_cur.sd));
        chk({tag, "_d2_hop"}, 64'(o2_hp), 64'(e2_cur.hp));
        chk({tag, "_d0_valid"}, 64'(o0_v), 64'(e0_cur.v));
        chk({tag, "_d0_srcdst"}, 64'(o0_sd), 64'(e0_cur.sd));
        chk({tag, "_d0_hop"}, 64'(o0_hp), 64'(e0_cur.hp));
        chk({tag, "_flags_d1"}, 64'({o1_em, o1_ed}), 64'({fm, fd}));
        chk({tag, "_flags_d2"}, 64'({o2_em, o2_ed}), 64'({fm, fd}));
    endtask

    task automatic set_ident();
        ctl = ctl5(5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [NP*AB-1:0] sd_base;
        int perm[NP];
        int j, tmp;

        sd_base = sd5(8'h10, 8'h11, 8'h12, 8'h13, 8'h14);
        tbl[0] = '{ctl5(5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001), 5'b11111,
                   hp5(3, 3, 3, 3, 3), 5'b11111, sd5(8'h11, 8'h12, 8'h13, 8'h14, 8'h10),
                   hp5(4, 4, 4, 4, 4), hp5(3, 3, 3, 3, 3), 1'b0, 1'b0};
        tbl[1] = '{ctl5(5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000), 5'b11111,
                   hp5(31, 30, 0, 0, 0), 5'b11111, sd_base,
                   hp5(31, 31, 1, 1, 1), hp5(31, 30, 0, 0, 0), 1'b0, 1'b0};
        tbl[2] = '{ctl5(5'b00001, 5'b00010, 5'b00011, 5'b01000, 5'b10000), 5'b11111,
                   hp5(3, 3, 3, 3, 3), 5'b11011, sd5(8'h10, 8'h11, 8'h00, 8'h13, 8'h14),
                   hp5(4, 4, 0, 4, 4), hp5(3, 3, 0, 3, 3), 1'b1, 1'b0};
        tbl[3] = '{ctl5(5'b10000, 5'b00010, 5'b00100, 5'b10000, 5'b00000), 5'b11111,
                   hp5(3, 3, 3, 3, 3), 5'b01111, sd5(8'h14, 8'h11, 8'h12, 8'h14, 8'h00),
                   hp5(4, 4, 4, 4, 0), hp5(3, 3, 3, 3, 0), 1'b0, 1'b1};
        tbl[4] = '{ctl5(5'b10000, 5'b00010, 5'b00100, 5'b10000, 5'b00000), 5'b01111,
                   hp5(3, 3, 3, 3, 3), 5'b00110, sd5(8'h00, 8'h11, 8'h12, 8'h00, 8'h00),
                   hp5(0, 4, 4, 0, 0), hp5(0, 3, 3, 0, 0), 1'b0, 1'b0};
        tbl[5] = '{ctl5(5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000), 5'b10101,
                   hp5(5, 5, 5, 5, 5), 5'b10101, sd5(8'h10, 8'h00, 8'h12, 8'h00, 8'h14),
                   hp5(6, 0, 6, 0, 6), hp5(5, 0, 5, 0, 5), 1'b0, 1'b0};

        pend = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset: load nonzero state and a sticky flag, then reset without an edge
        in_srcdst = sd_base;
        in_valid  = 5'b11111;
        in_hop    = hp5(7, 7, 7, 7, 7);
        ctl = ctl5(5'b00001, 5'b00010, 5'b00011, 5'b01000, 5'b10000);
        step_check("pre_rst_a");
        set_ident();
        step_check("pre_rst_b");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs_d1", 64'({o1_v, o1_hp} | 64'(o1_sd)), 64'd0);
        chk("rst_outputs_d2", 64'({o2_v, o2_hp} | 64'(o2_sd)), 64'd0);
        chk("rst_outputs_d0", 64'({o0_v, o0_hp} | 64'(o0_sd)), 64'd0);
        chk("rst_flags", 64'({o1_em, o1_ed, o2_em, o2_ed, o0_em, o0_ed}), 64'd0);
        rst_n = 1'b1;
        pend = '0; fm = 1'b0; fd = 1'b0;
        step_check("post_rst_1");
        step_check("post_rst_2");

        ctl = '0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Directed table: exact latency per instance
        for (int t = 0; t < 6; t++) begin
            ctl = tbl[t].ctl; in_valid = tbl[t].iv; in_hop = tbl[t].ih;
            in_srcdst = sd_base; err_clr = 1'b0;
            tick();
            chk($sformatf("v%0d_d1_valid", t), 64'(o1_v), 64'(tbl[t].ev));
            chk($sformatf("v%0d_d1_srcdst", t), 64'(o1_sd), 64'(tbl[t].esd));
            chk($sformatf("v%0d_d1_hop", t), 64'(o1_hp), 64'(tbl[t].eh1));
            chk($sformatf("v%0d_d0_hop", t), 64'(o0_hp), 64'(tbl[t].eh0));
            chk($sformatf("v%0d_d0_valid", t), 64'(o0_v), 64'(tbl[t].ev));
            chk($sformatf("v%0d_flags", t), 64'({o1_em, o1_ed, o2_em, o2_ed}),
                64'({tbl[t].em, tbl[t].ed, tbl[t].em, tbl[t].ed}));
            chk($sformatf("v%0d_d2_early", t), 64'(o2_v), 64'd0);
            ctl = '0; err_clr = 1'b1;
            tick();
            chk($sformatf("v%0d_d2_valid", t), 64'(o2_v), 64'(tbl[t].ev));
            chk($sformatf("v%0d_d2_srcdst", t), 64'(o2_sd), 64'(tbl[t].esd));
            chk($sformatf("v%0d_d2_hop", t), 64'(o2_hp), 64'(tbl[t].eh1));
            chk($sformatf("v%0d_cleared", t), 64'({o1_em, o1_ed}), 64'd0);
        end

        // Sticky multi-hot: holds, and set beats clear on the same edge
        err_clr = 1'b0; in_valid = 5'b11111; in_hop = hp5(3, 3, 3, 3, 3);
        ctl = ctl5(5'b00001, 5'b00010, 5'b00011, 5'b01000, 5'b10000);
        tick();
        chk("multi_set", 64'(o1_em), 64'd1);
        chk("multi_slot_invalid", 64'(o1_v[2]), 64'd0);
        set_ident();
        tick();
        chk("multi_hold", 64'({o1_em, o2_em}), 64'b11);
        ctl = ctl5(5'b00001, 5'b00010, 5'b00011, 5'b01000, 5'b10000); err_clr = 1'b1;
        tick();
        chk("multi_set_wins", 64'(o1_em), 64'd1);
        set_ident();
        tick();
        chk("multi_clear", 64'(o1_em), 64'd0);
        ctl = ctl5(5'b10000, 5'b00010, 5'b00100, 5'b10000, 5'b00000);
        tick();
        chk("dup_set_wins", 64'(o1_ed), 64'd1);
        set_ident();
        tick();
        chk("dup_clear", 64'(o1_ed), 64'd0);
        err_clr = 1'b0;

        // Streaming: legal one-hot selects, no input granted twice
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NP; k++) perm[k] = k;
            for (int k = NP - 1; k > 0; k--) begin
                j = int'($urandom_range(k, 0));
                tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
            end
            for (int o = 0; o < NP; o++)
                ctl[o*NP +: NP] = ($urandom_range(3, 0) == 0) ? 5'b0 : 5'(1 << perm[o]);
            in_valid = 5'($urandom);
            for (int k = 0; k < NP; k++) begin
                in_srcdst[k*AB +: AB] = 8'($urandom);
                in_hop[k*HB +: HB] = ($urandom_range(3, 0) == 0) ? 5'(29 + $urandom_range(2, 0))
                                                                 : 5'($urandom);
            end
            step_check("stream");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
